maxpool2x2_column: RTL
======================

Name: maxpool2x2_column

Overview:
- Streaming 2x2 max-pool stage directly downstream of the ReLU column stage.
- Consumes one feature-map column of COLUMN_SIZE 16-bit fp16 words per handshake. Buffers the even column and, on the odd column, emits one pooled column of COLUMN_SIZE/2 words.
- Output feeds the next conv layer's column loader through a valid/ready handshake.

Parameters:
- COLUMN_SIZE, 24: words per input column; must be even.
- IMAGE_WIDTH, 24: columns per feature map; must be even.
- Elaboration error if either parameter is odd.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- col_valid_i  input  1  input column valid.
- col_ready_o  output  1  block can accept a column this cycle.
- col_data_i  input  16 x COLUMN_SIZE  input column, post-ReLU fp16; index 0 = top row.
- out_valid_o  output  1  pooled column valid.
- out_ready_i  input  1  downstream accepts the pooled column.
- out_data_o  output  16 x COLUMN_SIZE/2  pooled column; word k = max of rows 2k and 2k+1.
- out_last_o  output  1  qualifies out_valid_o; high on the final pooled column of a feature map.

Behaviour:
- Reset (rst_n low, async):
  - out_valid_o=0, out_last_o=0, out_data_o all 0x0000.
  - Column buffer cleared; col counter=0; state=EMPTY.
  - col_ready_o=1 once reset is released.
- Transfers occur on an edge where valid&ready are both high; input and output sides are independent.
- Comparison:
  - Any input word with bit15 set (e.g. -0.0) is treated as 0x0000.
  - Otherwise words are ordered by unsigned compare of bits[14:0] (valid for non-negative fp16).
  - On ties, the value is identical, so no tie-break is needed.
- State EMPTY (no buffered column):
  - col_ready_o=1 regardless of output occupancy.
  - On accept: store the pairwise row max (rows 2k/2k+1) into the half buffer, COLUMN_SIZE/2 words; go to HALF.
- State HALF:
  - col_ready_o = !out_valid_o | out_ready_i.
  - On accept: out_data_o[k] <= max(buffer[k], max(col[2k], col[2k+1])).
  - Set out_valid_o=1; out_last_o=1 iff this column is counter index IMAGE_WIDTH-1; go to EMPTY.
- Output register:
  - out_valid_o clears on out_ready_i unless refilled in the same cycle.
  - Data and last are stable while out_valid_o=1 and out_ready_i=0.
- Latency: pooled column is valid on the edge after the odd column is accepted (1 cycle).
- Throughput: one input column per cycle sustained when out_ready_i is held high.
- Column counter:
  - Increments per accepted column; wraps IMAGE_WIDTH-1 -> 0.
  - Even index always lands in EMPTY, odd index always in HALF.
- Simultaneous events: in HALF with a pending output and out_ready_i=1, drain and refill on the same edge; out_valid_o stays 1 with new data.
- Backpressure: an EMPTY-state accept while the output is stalled is allowed; only the HALF-state accept stalls.
- Mid-operation reset: any buffered half-pair and pending output are discarded; counter returns to 0.
- col_data_i is ignored when not accepted. No combinational path from col_valid_i to out_*.

Test Plan:
- Reset with out_ready_i=1. Column A: rows r0..r23 = r*0x0100. Column B: all 0x0800 -> one output a cycle after B. Word k = max(0x0100*(2k+1), 0x0800): words 0..3 = 0x0800; word 4 = 0x0900; word 11 = 0x1700.
- Column containing 0x8000 next to 0x0001, paired with an all-zero column -> that output word = 0x0001.
- Stream 24 columns back-to-back, out_ready_i=1 -> 12 outputs; out_last_o high only on the 12th; the 25th column starts a new map with the counter wrapped.
- Hold out_ready_i=0 after the first output, then present columns 3 and 4:
  - Column 3 is accepted; col_ready_o drops in HALF.
  - out_data_o holds its value.
  - Raise out_ready_i -> column 4 is accepted the same cycle and out_valid_o remains 1 with new data.
- Assert rst_n=0 asynchronously between columns 1 and 2 (state HALF) -> outputs zero immediately. The next two columns form a fresh pair, and no stale data reaches out_data_o.
- Random valid/ready toggling for 1000 columns vs. a reference model -> no lost or duplicated columns, and data matches the model.

Source files
------------

// File: rtl/maxpool2x2_column.sv
// ============================================================================
// Module   : maxpool2x2_column
// Brief    : Streaming 2x2 max-pool over post-ReLU fp16 feature-map columns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module maxpool2x2_column #(
  parameter int COLUMN_SIZE = 24,
  parameter int IMAGE_WIDTH = 24
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                col_valid_i,
  output logic                                col_ready_o,
  input  logic [COLUMN_SIZE-1:0][15:0]        col_data_i,
  output logic                                out_valid_o,
  input  logic                                out_ready_i,
  output logic [COLUMN_SIZE/2-1:0][15:0]      out_data_o,
  output logic                                out_last_o
);

  localparam int c_HALF_SIZE = COLUMN_SIZE / 2;
  localparam int c_CNT_W     = (IMAGE_WIDTH > 2) ? $clog2(IMAGE_WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_IDX = c_CNT_W'(IMAGE_WIDTH - 1);

  generate
    if ((COLUMN_SIZE % 2) != 0) begin : g_col_size_odd
      $error("maxpool2x2_column: COLUMN_SIZE must be even");
    end
    if ((IMAGE_WIDTH % 2) != 0) begin : g_image_width_odd
      $error("maxpool2x2_column: IMAGE_WIDTH must be even");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_HALF  = 1'b1
  } state_t;

  state_t                           r_state;
  logic [c_CNT_W-1:0]               r_cnt;
  logic [c_HALF_SIZE-1:0][15:0]     r_buf;
  logic [c_HALF_SIZE-1:0][15:0]     r_out_data;
  logic                             r_out_valid;
  logic                             r_out_last;

  logic [c_HALF_SIZE-1:0][15:0]     w_pair;
  logic [c_HALF_SIZE-1:0][15:0]     w_pool;
  logic                             w_accept;

  // Negative inputs (sign bit set) count as zero; for non-negative fp16 the
  // magnitude bits order the same way as the values they encode.
  function automatic logic [15:0] relu_max(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] sa;
    logic [15:0] sb;
    sa = a[15] ? 16'h0000 : a;
    sb = b[15] ? 16'h0000 : b;
    return (sa[14:0] > sb[14:0]) ? sa : sb;
  endfunction

  generate
    for (genvar k = 0; k < c_HALF_SIZE; k++) begin : g_pair
      assign w_pair[k] = relu_max(col_data_i[2*k], col_data_i[2*k+1]);
      assign w_pool[k] = relu_max(r_buf[k], w_pair[k]);
    end
  endgenerate

  // Only the pooling column needs the output register free.
  assign col_ready_o = (r_state == ST_EMPTY) || !r_out_valid || out_ready_i;
  assign w_accept    = col_valid_i && col_ready_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_cnt       <= '0;
      r_buf       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept) begin
        r_cnt <= (r_cnt == c_LAST_IDX) ? '0 : r_cnt + c_CNT_W'(1);
        if (r_state == ST_EMPTY) begin
          r_buf   <= w_pair;
          r_state <= ST_HALF;
        end else begin
          r_out_data  <= w_pool;
          r_out_valid <= 1'b1;
          r_out_last  <= (r_cnt == c_LAST_IDX);
          r_state     <= ST_EMPTY;
        end
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign out_last_o  = r_out_last;

endmodule

`default_nettype wire
